eh2_ifu_ghr_tracker: RTL and testbench

- Maintains the per-thread global branch history registers (GHR) that feed the BHT index hash in the IFU branch predictor.
- Keeps two copies per thread:
  - a speculative fetch GHR, updated on every predicted branch at fetch;
  - a committed GHR, updated on every branch resolved in EXU.
- Restores the fetch GHR on mispredict or flush.
- Bounds the number of unresolved speculative updates per thread and back-pressures fetch when that bound is reached.

---
 rtl/eh2_ifu_ghr_tracker_if.sv | 54 +++++
 rtl/eh2_ifu_ghr_tracker.sv | 157 +++++++++++++++
 tb/tb_eh2_ifu_ghr_tracker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eh2_ifu_ghr_tracker_if.sv
// Fetch/resolve/flush event bus and per-thread GHR status for eh2_ifu_ghr_tracker.
// EH2_GHR_PERF_EN adds the per-thread performance counter outputs.
interface eh2_ifu_ghr_tracker_if #(
  parameter int NUM_THREADS  = 2,
  parameter int BHT_GHR_SIZE = 8,
  parameter int CNT_W        = 4
);
  logic                                ifu_pred_valid;
  logic                                ifu_pred_tid;
  logic                                ifu_pred_taken;
  logic                                exu_res_valid;
  logic                                exu_res_tid;
  logic                                exu_res_taken;
  logic                                exu_res_mispred;
  logic                                dec_flush_valid;
  logic                                dec_flush_tid;
  logic [NUM_THREADS*BHT_GHR_SIZE-1:0] fetch_ghr;
  logic [NUM_THREADS*BHT_GHR_SIZE-1:0] commit_ghr;
  logic [NUM_THREADS-1:0]              ghr_full;
  logic [NUM_THREADS*CNT_W-1:0]        ghr_inflight;
  logic [NUM_THREADS-1:0]              ghr_err;
`ifdef EH2_GHR_PERF_EN
  logic [NUM_THREADS*32-1:0]           ghr_perf_pred;
  logic [NUM_THREADS*32-1:0]           ghr_perf_mp;

  modport master (
    output ifu_pred_valid, ifu_pred_tid, ifu_pred_taken,
    output exu_res_valid, exu_res_tid, exu_res_taken, exu_res_mispred,
    output dec_flush_valid, dec_flush_tid,
    input  fetch_ghr, commit_ghr, ghr_full, ghr_inflight, ghr_err,
    input  ghr_perf_pred, ghr_perf_mp
  );
  modport slave (
    input  ifu_pred_valid, ifu_pred_tid, ifu_pred_taken,
    input  exu_res_valid, exu_res_tid, exu_res_taken, exu_res_mispred,
    input  dec_flush_valid, dec_flush_tid,
    output fetch_ghr, commit_ghr, ghr_full, ghr_inflight, ghr_err,
    output ghr_perf_pred, ghr_perf_mp
  );
`else
  modport master (
    output ifu_pred_valid, ifu_pred_tid, ifu_pred_taken,
    output exu_res_valid, exu_res_tid, exu_res_taken, exu_res_mispred,
    output dec_flush_valid, dec_flush_tid,
    input  fetch_ghr, commit_ghr, ghr_full, ghr_inflight, ghr_err
  );
  modport slave (
    input  ifu_pred_valid, ifu_pred_tid, ifu_pred_taken,
    input  exu_res_valid, exu_res_tid, exu_res_taken, exu_res_mispred,
    input  dec_flush_valid, dec_flush_tid,
    output fetch_ghr, commit_ghr, ghr_full, ghr_inflight, ghr_err
  );
`endif
endinterface

// File: rtl/eh2_ifu_ghr_tracker.sv
// Per-thread speculative/committed global branch history with in-flight bound.
// Optional macro EH2_GHR_PERF_EN adds saturating prediction/mispredict counters.
module eh2_ifu_ghr_thread #(
  parameter int S            = 8,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred,
  input  logic             pred_taken,
  input  logic             res,
  input  logic             res_taken,
  input  logic             res_mispred,
  input  logic             flush,
  output logic [S-1:0]     f_q,
  output logic [S-1:0]     c_q,
  output logic [CNT_W-1:0] n_q,
  output logic             full_q,
  output logic             err_q
`ifdef EH2_GHR_PERF_EN
  ,
  output logic [31:0]      perf_pred_q,
  output logic [31:0]      perf_mp_q
`endif
);
  logic             mp, kill, acc;
  logic [S-1:0]     f_d, c_d;
  logic [CNT_W-1:0] n_d;
  logic             full_d, err_d;

  always_comb begin
    mp   = res & res_mispred;
    kill = mp | flush;
    acc  = pred & ~full_q;

    c_d = res ? {c_q[S-2:0], res_taken} : c_q;

    // Recovery rebuilds fetch history from the committed copy (old C).
    f_d = f_q;
    if (mp | (flush & res))
      f_d = {c_q[S-2:0], res_taken};
    else if (flush)
      f_d = c_q;
    else if (acc)
      f_d = {f_q[S-2:0], pred_taken};

    n_d   = n_q;
    err_d = err_q;
    if (kill) begin
      n_d = '0;
    end else begin
      if (acc && !res)
        n_d = n_q + CNT_W'(1);
      else if (res && !acc && n_q != '0)
        n_d = n_q - CNT_W'(1);
      if (res && n_q == '0) err_d = 1'b1;
      if (pred && full_q)   err_d = 1'b1;
    end

    full_d = (n_d == CNT_W'(MAX_INFLIGHT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      c_q    <= '0;
      n_q    <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      f_q    <= f_d;
      c_q    <= c_d;
      n_q    <= n_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

`ifdef EH2_GHR_PERF_EN
  logic [31:0] perf_pred_d, perf_mp_d;

  always_comb begin
    perf_pred_d = perf_pred_q;
    perf_mp_d   = perf_mp_q;
    if (acc && !kill && perf_pred_q != '1) perf_pred_d = perf_pred_q + 32'd1;
    if (mp && perf_mp_q != '1)             perf_mp_d   = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_pred_q <= '0;
      perf_mp_q   <= '0;
    end else begin
      perf_pred_q <= perf_pred_d;
      perf_mp_q   <= perf_mp_d;
    end
  end
`endif
endmodule

module eh2_ifu_ghr_tracker #(
  parameter int NUM_THREADS  = 2,
  parameter int BHT_GHR_SIZE = 8,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  eh2_ifu_ghr_tracker_if.slave    io
);
  localparam int S = BHT_GHR_SIZE;

  logic [NUM_THREADS-1:0] pred_t, res_t, fl_t;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    // With a single thread every event belongs to thread 0.
    if (NUM_THREADS == 1) begin : g_one
      always_comb begin
        pred_t[t] = io.ifu_pred_valid;
        res_t[t]  = io.exu_res_valid;
        fl_t[t]   = io.dec_flush_valid;
      end
    end else begin : g_multi
      always_comb begin
        pred_t[t] = io.ifu_pred_valid  & (io.ifu_pred_tid  == 1'(t));
        res_t[t]  = io.exu_res_valid   & (io.exu_res_tid   == 1'(t));
        fl_t[t]   = io.dec_flush_valid & (io.dec_flush_tid == 1'(t));
      end
    end

    eh2_ifu_ghr_thread #(
      .S            (S),
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_thr (
      .clk         (clk),
      .rst         (rst),
      .pred        (pred_t[t]),
      .pred_taken  (io.ifu_pred_taken),
      .res         (res_t[t]),
      .res_taken   (io.exu_res_taken),
      .res_mispred (io.exu_res_mispred),
      .flush       (fl_t[t]),
      .f_q         (io.fetch_ghr[t*S +: S]),
      .c_q         (io.commit_ghr[t*S +: S]),
      .n_q         (io.ghr_inflight[t*CNT_W +: CNT_W]),
      .full_q      (io.ghr_full[t]),
      .err_q       (io.ghr_err[t])
`ifdef EH2_GHR_PERF_EN
      ,
      .perf_pred_q (io.ghr_perf_pred[t*32 +: 32]),
      .perf_mp_q   (io.ghr_perf_mp[t*32 +: 32])
`endif
    );
  end
endmodule

// File: tb/tb_eh2_ifu_ghr_tracker.sv
// Scoreboard bench for eh2_ifu_ghr_tracker: directed scenarios plus random traffic.
module tb_eh2_ifu_ghr_tracker;
  localparam int NT = 2, S = 8, MAXI = 8, CW = 4;
  localparam int MASK = (1 << S) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eh2_ifu_ghr_tracker_if #(.NUM_THREADS(NT), .BHT_GHR_SIZE(S), .CNT_W(CW)) bus ();

  eh2_ifu_ghr_tracker #(.NUM_THREADS(NT), .BHT_GHR_SIZE(S), .MAX_INFLIGHT(MAXI), .CNT_W(CW))
    dut (.clk(clk), .rst(rst), .io(bus));

  typedef struct {
    logic [NT*S-1:0]  fetch;
    logic [NT*S-1:0]  commit;
    logic [NT-1:0]    full;
    logic [NT*CW-1:0] infl;
    logic [NT-1:0]    err;
    logic [NT*32-1:0] ppred;
    logic [NT*32-1:0] pmp;
  } snap_t;

  snap_t q[$];
  bit    mon_on = 1'b0;
  int    n_vec = 0, n_bad = 0;

  // Reference state: plain integers per thread.
  int          mF[NT], mC[NT], mN[NT];
  bit          mE[NT];
  int unsigned mPP[NT], mMP[NT];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int t = 0; t < NT; t++) begin
      mF[t] = 0; mC[t] = 0; mN[t] = 0; mE[t] = 0; mPP[t] = 0; mMP[t] = 0;
    end
  endfunction

  function automatic int shl(int x, bit b);
    return ((x << 1) | int'(b)) & MASK;
  endfunction

  function automatic void mstep(bit pv, bit ptid, bit pt, bit rv, bit rtid, bit rt, bit rm,
                                bit fv, bit ftid);
    for (int t = 0; t < NT; t++) begin
      bit p, r, m, f, kill, full, acc;
      p    = pv && (ptid == t[0]);
      r    = rv && (rtid == t[0]);
      m    = r && rm;
      f    = fv && (ftid == t[0]);
      kill = m || f;
      full = (mN[t] == MAXI);
      acc  = p && !full;
      if (kill) begin
        mF[t] = r ? shl(mC[t], rt) : mC[t];
        mN[t] = 0;
      end else begin
        if (acc) mF[t] = shl(mF[t], pt);
        if (p && full) mE[t] = 1;
        if (r && mN[t] == 0) mE[t] = 1;
        mN[t] = mN[t] + int'(acc) - int'(r);
        if (mN[t] < 0) mN[t] = 0;
      end
      if (acc && !kill && mPP[t] != 32'hFFFF_FFFF) mPP[t]++;
      if (m && mMP[t] != 32'hFFFF_FFFF) mMP[t]++;
      if (r) mC[t] = shl(mC[t], rt);
    end
  endfunction

  function automatic snap_t msnap();
    snap_t s;
    for (int t = 0; t < NT; t++) begin
      int f, c, n;
      f = mF[t]; c = mC[t]; n = mN[t];
      s.fetch[t*S +: S]   = f[S-1:0];
      s.commit[t*S +: S]  = c[S-1:0];
      s.infl[t*CW +: CW]  = n[CW-1:0];
      s.full[t]           = (mN[t] == MAXI);
      s.err[t]            = mE[t];
      s.ppred[t*32 +: 32] = mPP[t];
      s.pmp[t*32 +: 32]   = mMP[t];
    end
    return s;
  endfunction

  task automatic drive(bit pv, bit ptid, bit pt, bit rv, bit rtid, bit rt, bit rm, bit fv, bit ftid);
    bus.ifu_pred_valid = pv;  bus.ifu_pred_tid = ptid; bus.ifu_pred_taken = pt;
    bus.exu_res_valid = rv;   bus.exu_res_tid = rtid;  bus.exu_res_taken = rt;
    bus.exu_res_mispred = rm; bus.dec_flush_valid = fv; bus.dec_flush_tid = ftid;
  endtask

  // Drive one cycle of events and queue the state expected after the next edge.
  task automatic step(bit pv, bit ptid, bit pt, bit rv, bit rtid, bit rt, bit rm, bit fv, bit ftid);
    @(posedge clk); #1;
    drive(pv, ptid, pt, rv, rtid, rt, rm, fv, ftid);
    mstep(pv, ptid, pt, rv, rtid, rt, rm, fv, ftid);
    q.push_back(msnap());
  endtask

  task automatic pred(bit tid, bit tk);          step(1, tid, tk, 0, 0, 0, 0, 0, 0); endtask
  task automatic resolve(bit tid, bit tk, bit m); step(0, 0, 0, 1, tid, tk, m, 0, 0); endtask
  task automatic idle();                          step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Asynchronous reset asserted mid-cycle with live traffic on the inputs.
  task automatic do_reset();
    mon_on = 1'b0;
    drive(1, $urandom % 2, 1, 1, $urandom % 2, 1, $urandom % 2, 0, 0);
    #4 rst = 1'b1;
    #1;
    chk("rst_fetch",  64'(bus.fetch_ghr), 0);
    chk("rst_commit", 64'(bus.commit_ghr), 0);
    chk("rst_infl",   64'(bus.ghr_inflight), 0);
    chk("rst_full",   64'(bus.ghr_full), 0);
    chk("rst_err",    64'(bus.ghr_err), 0);
`ifdef EH2_GHR_PERF_EN
    chk("rst_ppred",  64'(bus.ghr_perf_pred), 0);
    chk("rst_pmp",    64'(bus.ghr_perf_mp), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    mreset();
    q.push_back(msnap());
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mstep(0, 0, 0, 0, 0, 0, 0, 0, 0);
    q.push_back(msnap());
    mon_on = 1'b1;
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk); #3;
      if (mon_on) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL sb_empty got=none exp=entry t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_fetch",  64'(bus.fetch_ghr),    64'(e.fetch));
          chk("sb_commit", 64'(bus.commit_ghr),   64'(e.commit));
          chk("sb_infl",   64'(bus.ghr_inflight), 64'(e.infl));
          chk("sb_full",   64'(bus.ghr_full),     64'(e.full));
          chk("sb_err",    64'(bus.ghr_err),      64'(e.err));
`ifdef EH2_GHR_PERF_EN
          chk("sb_ppred",  64'(bus.ghr_perf_pred), 64'(e.ppred));
          chk("sb_pmp",    64'(bus.ghr_perf_mp),   64'(e.pmp));
`endif
        end
      end
    end
  end

  initial begin : stim
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mreset();
    @(posedge clk); #1;
    do_reset();

    // T,N,T,T on thread 0
    pred(0, 1); pred(0, 0); pred(0, 1); pred(0, 1); idle();
    #4;
    chk("dir_f0_0b", 64'(bus.fetch_ghr[7:0]), 64'h0B);
    chk("dir_n0_4",  64'(bus.ghr_inflight[3:0]), 4);
    chk("dir_c0_0",  64'(bus.commit_ghr[7:0]), 0);

    resolve(0, 1, 0); resolve(0, 0, 0); idle();
    #4;
    chk("dir_c0_02", 64'(bus.commit_ghr[7:0]), 64'h02);
    chk("dir_n0_2",  64'(bus.ghr_inflight[3:0]), 2);
    chk("dir_f0_hold", 64'(bus.fetch_ghr[7:0]), 64'h0B);

    // mispredict (taken) with a same-cycle thread-0 prediction
    step(1, 0, 1, 1, 0, 1, 1, 0, 0); idle();
    #4;
    chk("dir_mp_f0",  64'(bus.fetch_ghr[7:0]), 64'h05);
    chk("dir_mp_c0",  64'(bus.commit_ghr[7:0]), 64'h05);
    chk("dir_mp_n0",  64'(bus.ghr_inflight[3:0]), 0);
    chk("dir_mp_e0",  64'(bus.ghr_err[0]), 0);

    repeat (8) pred(1, 1);
    idle();
    #4;
    chk("dir_full1", 64'(bus.ghr_full[1]), 1);
    chk("dir_f1_ff", 64'(bus.fetch_ghr[15:8]), 64'hFF);
    pred(1, 0); idle();
    #4;
    chk("dir_ovf_f1", 64'(bus.fetch_ghr[15:8]), 64'hFF);
    chk("dir_ovf_e1", 64'(bus.ghr_err[1]), 1);
    chk("dir_ovf_n1", 64'(bus.ghr_inflight[7:4]), 8);
    chk("dir_ovf_f0", 64'(bus.fetch_ghr[7:0]), 64'h05);
    chk("dir_ovf_e0", 64'(bus.ghr_err[0]), 0);

    @(posedge clk); #1;
    do_reset();
    // build F=3C, C=0F, N=3 on thread 0
    pred(0, 0); pred(0, 1); pred(0, 1); pred(0, 1); pred(0, 1); pred(0, 0); pred(0, 0);
    repeat (4) resolve(0, 1, 0);
    idle();
    #4;
    chk("dir_pre_f0", 64'(bus.fetch_ghr[7:0]), 64'h3C);
    chk("dir_pre_c0", 64'(bus.commit_ghr[7:0]), 64'h0F);
    chk("dir_pre_n0", 64'(bus.ghr_inflight[3:0]), 3);
`ifdef EH2_GHR_PERF_EN
    chk("dir_perf_p0", 64'(bus.ghr_perf_pred[31:0]), 7);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 1, 0); idle();
    #4;
    chk("dir_fl_f0", 64'(bus.fetch_ghr[7:0]), 64'h0F);
    chk("dir_fl_n0", 64'(bus.ghr_inflight[3:0]), 0);
    chk("dir_fl_c0", 64'(bus.commit_ghr[7:0]), 64'h0F);
    resolve(0, 1, 0); idle();
    #4;
    chk("dir_unf_e0", 64'(bus.ghr_err[0]), 1);
    chk("dir_unf_n0", 64'(bus.ghr_inflight[3:0]), 0);

    // random traffic, two resolve densities, with an asynchronous reset between
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        bit rv;
        rv = (ph == 0) ? ($urandom % 3 == 0) : ($urandom % 2 == 0);
        step($urandom % 4 != 0, $urandom % 2, $urandom % 2,
             rv, $urandom % 2, $urandom % 2, rv && ($urandom % 12 == 0),
             $urandom % 40 == 0, $urandom % 2);
      end
      if (ph == 0) begin
        @(posedge clk); #1;
        do_reset();
      end
    end
    idle(); idle(); idle();
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
